// File: rtl/oled_pkg.sv
// Shared state type, DC codes and the panel bring-up command table for oled_seq.
package oled_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_LOW   = 3'd1,
        RST_WAIT  = 3'd2,
        CMD_ISSUE = 3'd3,
        CMD_WAIT  = 3'd4,
        READY     = 3'd5,
        PIX_WAIT  = 3'd6,
        FAULT     = 3'd7
    } oled_state_e;

    localparam logic [1:0] DC_CMD  = 2'b00;
    localparam logic [1:0] DC_DATA = 2'b01;

    localparam int unsigned INIT_LEN = 8;
    localparam int unsigned IDX_W    = $clog2(INIT_LEN);

    // Display off, clock divide, mux ratio, charge pump on, display on.
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'h8D, 8'h14, 8'hAF
    };

endpackage

// File: rtl/oled_init_rom.sv
// Combinational index -> init command byte lookup for the OLED sequencer.
module oled_init_rom
    import oled_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       cmd_byte
);

    // Table lookup; the sequencer registers the byte on its way to DATA.
    always_comb begin
        cmd_byte = INIT_ROM[idx];
    end

endmodule

// File: rtl/oled_seq.sv
// OLED power-up sequencer: hard reset, init command stream, then a pixel byte path.
// Optional WRITE_DONE watchdog enabled by defining OLED_SEQ_TIMEOUT_EN.
module oled_seq
    import oled_pkg::*;
#(
    parameter logic [19:0] RST_CYCLES     = 20'd1000000,
    parameter logic [19:0] WAIT_CYCLES    = 20'd1000000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    output logic       DONE,
    output logic       RST_OLED,
    output logic       WRITE_START,
    input  logic       WRITE_DONE,
    output logic [9:0] DATA,
    input  logic       PIX_REQ,
    input  logic [7:0] PIX_DATA,
    output logic       PIX_ACK,
    output logic       ERR
);

    oled_state_e      state_r, state_nxt_s;
    logic [19:0]      cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [IDX_W-1:0] idx_r, idx_nxt_s;
    logic [7:0]       rom_byte_s;
    logic [9:0]       data_r, data_nxt_s;
    logic             wstart_r, wstart_nxt_s;
    logic             done_r, rst_oled_r;
    logic             grant_s, wait_live_s, wr_done_s, timeout_s;

    oled_init_rom u_rom (
        .idx      (idx_nxt_s),
        .cmd_byte (rom_byte_s)
    );

    // The cycle in which a pixel WRITE_START is high does not count as waiting.
    assign wait_live_s = (state_r == CMD_WAIT) || ((state_r == PIX_WAIT) && !wstart_r);
    assign wr_done_s   = wait_live_s && WRITE_DONE;
    assign cnt_inc_s   = (cnt_r == 20'hFFFFF) ? cnt_r : cnt_r + 20'd1;

    // Next-state, phase counter and init index.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        grant_s     = 1'b0;
        case (state_r)
            IDLE, FAULT: begin
                if (START) begin
                    state_nxt_s = RST_LOW;
                    cnt_nxt_s   = 20'd0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RST_LOW: begin
                if (cnt_r >= RST_CYCLES - 20'd1) begin
                    state_nxt_s = RST_WAIT;
                    cnt_nxt_s   = 20'd0;
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            RST_WAIT: begin
                if (cnt_r >= WAIT_CYCLES - 20'd1) begin
                    state_nxt_s = CMD_ISSUE;
                    cnt_nxt_s   = 20'd0;
                    idx_nxt_s   = {IDX_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                end
            end
            CMD_ISSUE: begin
                state_nxt_s = CMD_WAIT;
            end
            CMD_WAIT: begin
                if (wr_done_s) begin
                    if (idx_r == IDX_W'(INIT_LEN - 1)) begin
                        state_nxt_s = READY;
                        idx_nxt_s   = {IDX_W{1'b0}};
                    end else begin
                        state_nxt_s = CMD_ISSUE;
                        idx_nxt_s   = idx_r + IDX_W'(1);
                    end
                end else if (timeout_s) begin
                    state_nxt_s = FAULT;
                end else begin
                    state_nxt_s = CMD_WAIT;
                end
            end
            READY: begin
                if (PIX_REQ) begin
                    state_nxt_s = PIX_WAIT;
                    grant_s     = 1'b1;
                end else begin
                    state_nxt_s = READY;
                end
            end
            PIX_WAIT: begin
                if (wr_done_s) begin
                    state_nxt_s = READY;
                end else if (timeout_s) begin
                    state_nxt_s = FAULT;
                end else begin
                    state_nxt_s = PIX_WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output values for the upcoming state; DATA is latched once per write.
    always_comb begin
        wstart_nxt_s = (state_nxt_s == CMD_ISSUE) || grant_s;
        data_nxt_s   = data_r;
        case (state_nxt_s)
            CMD_ISSUE: data_nxt_s = {DC_CMD, rom_byte_s};
            PIX_WAIT: begin
                if (grant_s) begin
                    data_nxt_s = {DC_DATA, PIX_DATA};
                end else begin
                    data_nxt_s = data_r;
                end
            end
            CMD_WAIT, READY: data_nxt_s = data_r;
            default:         data_nxt_s = 10'd0;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r    <= IDLE;
            cnt_r      <= 20'd0;
            idx_r      <= {IDX_W{1'b0}};
            data_r     <= 10'd0;
            wstart_r   <= 1'b0;
            done_r     <= 1'b0;
            rst_oled_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            idx_r      <= idx_nxt_s;
            data_r     <= data_nxt_s;
            wstart_r   <= wstart_nxt_s;
            done_r     <= (state_nxt_s == READY) || (state_nxt_s == PIX_WAIT);
            rst_oled_r <= (state_nxt_s != RST_LOW);
        end
    end

`ifdef OLED_SEQ_TIMEOUT_EN
    logic [15:0] wd_r;
    logic        err_r;

    assign timeout_s = wait_live_s && (wd_r >= TIMEOUT_CYCLES - 16'd1);

    // Watchdog counts live wait cycles; ERR follows the FAULT state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wd_r  <= 16'd0;
            err_r <= 1'b0;
        end else begin
            wd_r  <= (wait_live_s && (state_nxt_s == state_r)) ? wd_r + 16'd1 : 16'd0;
            err_r <= (state_nxt_s == FAULT);
        end
    end

    assign ERR = err_r;
`else
    assign timeout_s = 1'b0;
    assign ERR       = 1'b0;
`endif

    assign DONE        = done_r;
    assign RST_OLED    = rst_oled_r;
    assign WRITE_START = wstart_r;
    assign DATA        = data_r;
    assign PIX_ACK     = wr_done_s && (state_r == PIX_WAIT);

endmodule

// File: tb/tb_oled_seq.sv
// Self-checking bench for oled_seq: behavioural model checked every cycle plus directed literals.
module tb_oled_seq;

    localparam logic [19:0] RC  = 20'd4;
    localparam logic [19:0] WC  = 20'd3;
    localparam logic [15:0] TO  = 16'd10;
    localparam int          LEN = 8;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       START;
    logic       PIX_REQ;
    logic [7:0] PIX_DATA;
    logic       resp_done;
    logic       spur_done;
    logic       resp_en = 1'b1;
    logic       WRITE_DONE;
    logic       DONE, RST_OLED, WRITE_START, PIX_ACK, ERR;
    logic [9:0] DATA;

    int n_checks = 0;
    int n_fail   = 0;
    int resp_cnt = 0;

    logic [7:0] rom_tbl [LEN] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'h8D, 8'h14, 8'hAF};

    assign WRITE_DONE = resp_done | spur_done;

    oled_seq #(
        .RST_CYCLES     (RC),
        .WAIT_CYCLES    (WC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .START       (START),
        .DONE        (DONE),
        .RST_OLED    (RST_OLED),
        .WRITE_START (WRITE_START),
        .WRITE_DONE  (WRITE_DONE),
        .DATA        (DATA),
        .PIX_REQ     (PIX_REQ),
        .PIX_DATA    (PIX_DATA),
        .PIX_ACK     (PIX_ACK),
        .ERR         (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Model: elapsed time since START, commands issued/acknowledged, one write in flight.
    logic       m_clk_seen, m_active, m_fault, m_busy, m_pix, m_ws;
    int         m_t, m_issued, m_acked, m_wcnt;
    logic [9:0] m_data;

    task automatic model_reset();
        m_clk_seen = 1'b0; m_active = 1'b0; m_fault = 1'b0;
        m_busy = 1'b0; m_pix = 1'b0; m_ws = 1'b0;
        m_t = 0; m_issued = 0; m_acked = 0; m_wcnt = 0;
        m_data = 10'd0;
    endtask

    task automatic model_step();
        logic live, grant;
        live  = m_busy && !m_ws;
        grant = m_active && (m_acked == LEN) && !m_busy && PIX_REQ;
        m_clk_seen = 1'b1;
        m_ws = 1'b0;
        if (!m_active) begin
            if (START) begin
                m_active = 1'b1; m_fault = 1'b0; m_t = 0;
                m_issued = 0; m_acked = 0; m_busy = 1'b0; m_pix = 1'b0;
                m_data = 10'd0; m_wcnt = 0;
            end
        end else begin
            if (m_t < 100000) m_t++;
            if (live && WRITE_DONE) begin
                m_busy = 1'b0;
                if (!m_pix) m_acked++;
                m_pix = 1'b0;
            end else if (live) begin
                m_wcnt++;
`ifdef OLED_SEQ_TIMEOUT_EN
                if (m_wcnt >= int'(TO)) begin
                    m_active = 1'b0; m_fault = 1'b1; m_busy = 1'b0;
                    m_pix = 1'b0; m_data = 10'd0;
                end
`endif
            end
            if (m_active && !m_busy) begin
                if (grant) begin
                    m_ws = 1'b1; m_busy = 1'b1; m_pix = 1'b1; m_wcnt = 0;
                    m_data = {2'b01, PIX_DATA};
                end else if (m_t >= int'(RC + WC) && m_issued < LEN) begin
                    m_ws = 1'b1; m_busy = 1'b1; m_wcnt = 0;
                    m_data = {2'b00, rom_tbl[m_issued]};
                    m_issued++;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) model_reset();
            else        model_step();
        end
    end

    // Compare every cycle on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            check("cyc_done", 10'(DONE), 10'(m_active && (m_acked == LEN)));
            check("cyc_rst_oled", 10'(RST_OLED), 10'(m_clk_seen && !(m_active && m_t < int'(RC))));
            check("cyc_write_start", 10'(WRITE_START), 10'(m_ws));
            check("cyc_data", DATA, m_active ? m_data : 10'd0);
            check("cyc_pix_ack", 10'(PIX_ACK), 10'(m_busy && m_pix && !m_ws && WRITE_DONE));
            check("cyc_err", 10'(ERR), 10'(m_fault));
        end
    end

    // SPI writer stand-in: WRITE_DONE five cycles after each WRITE_START.
    initial begin
        resp_done = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            resp_done = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) resp_done = 1'b1;
            end
            if (resp_en && WRITE_START) resp_cnt = 5;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        int         cnt;
        int         acks;
        int         ack_ok;
        int         nws;
        logic       poked;
        logic [9:0] got [$];

        RST_N = 1'b0; START = 1'b0; PIX_REQ = 1'b0; PIX_DATA = 8'h00; spur_done = 1'b0;
        tick(2);
        check("reset_done", 10'(DONE), 10'd0);
        check("reset_write_start", 10'(WRITE_START), 10'd0);
        check("reset_data", DATA, 10'd0);
        check("reset_rst_oled", 10'(RST_OLED), 10'd0);
        check("reset_pix_ack", 10'(PIX_ACK), 10'd0);
        check("reset_err", 10'(ERR), 10'd0);
        RST_N = 1'b1;
        tick(1);
        check("rst_oled_after_release", 10'(RST_OLED), 10'd1);
        tick(2);

        // Power-up timing, with a spurious WRITE_DONE during RST_WAIT.
        START = 1'b1; tick(1); START = 1'b0;
        cnt = 0;
        while (RST_OLED == 1'b0 && cnt < 100) begin cnt++; tick(1); end
        check("rst_low_cycles", 10'(cnt), 10'd4);
        cnt = 0;
        spur_done = 1'b1;
        while (WRITE_START == 1'b0 && cnt < 100) begin cnt++; tick(1); spur_done = 1'b0; end
        spur_done = 1'b0;
        check("first_cmd_gap", 10'(cnt), 10'd3);

        // Init stream, with a START poked while a command is outstanding.
        poked = 1'b0;
        for (int c = 0; c < 400 && !DONE; c++) begin
            if (WRITE_START) got.push_back(DATA);
            if (got.size() == 2 && !WRITE_START && !poked) begin
                START = 1'b1; poked = 1'b1;
            end else begin
                START = 1'b0;
            end
            tick(1);
        end
        START = 1'b0;
        check("init_count", 10'(got.size()), 10'(LEN));
        for (int i = 0; i < got.size() && i < LEN; i++) begin
            check("init_word", got[i], {2'b00, rom_tbl[i]});
        end
        check("done_after_init", 10'(DONE), 10'd1);

        // Pixel write; PIX_DATA changes after the latch.
        PIX_DATA = 8'hA5; PIX_REQ = 1'b1;
        tick(1);
        PIX_REQ = 1'b0; PIX_DATA = 8'h3C;
        check("pix_write_start", 10'(WRITE_START), 10'd1);
        check("pix_data", DATA, 10'h1A5);
        acks = 0; ack_ok = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (PIX_ACK) begin
                acks++;
                if (WRITE_DONE) ack_ok++;
            end
            if (c == 3) check("pix_data_hold", DATA, 10'h1A5);
        end
        check("pix_ack_count", 10'(acks), 10'd1);
        check("pix_ack_with_done", 10'(ack_ok), 10'd1);
        check("pix_done_level", 10'(DONE), 10'd1);

        // Reset in CMD_WAIT at index 3, then restart from index 0.
        tick(1);
        RST_N = 1'b0; tick(1); RST_N = 1'b1; tick(2);
        START = 1'b1; tick(1); START = 1'b0;
        nws = 0;
        for (int c = 0; c < 300 && nws < 4; c++) begin
            tick(1);
            if (WRITE_START) nws++;
        end
        check("mid_cmd_index", 10'(nws), 10'd4);
        tick(2);
        RST_N = 1'b0;
        #1;
        check("midrst_done", 10'(DONE), 10'd0);
        check("midrst_write_start", 10'(WRITE_START), 10'd0);
        check("midrst_data", DATA, 10'd0);
        check("midrst_rst_oled", 10'(RST_OLED), 10'd0);
        check("midrst_pix_ack", 10'(PIX_ACK), 10'd0);
        check("midrst_err", 10'(ERR), 10'd0);
        tick(1);
        RST_N = 1'b1; tick(2);
        START = 1'b1; tick(1); START = 1'b0;
        cnt = 0;
        while (WRITE_START == 1'b0 && cnt < 100) begin cnt++; tick(1); end
        check("restart_first_word", DATA, 10'h0AE);
        cnt = 0;
        while (DONE == 1'b0 && cnt < 400) begin cnt++; tick(1); end
        check("restart_done", 10'(DONE), 10'd1);

        // Writer that never answers.
        tick(1);
        resp_en = 1'b0;
        RST_N = 1'b0; tick(1); RST_N = 1'b1; tick(2);
        START = 1'b1; tick(1); START = 1'b0;
        cnt = 0;
        while (WRITE_START == 1'b0 && cnt < 100) begin cnt++; tick(1); end
        tick(1);
`ifdef OLED_SEQ_TIMEOUT_EN
        cnt = 0;
        while (ERR == 1'b0 && cnt < 100) begin cnt++; tick(1); end
        check("timeout_cycles", 10'(cnt), 10'd10);
        check("fault_done", 10'(DONE), 10'd0);
        START = 1'b1; tick(1); START = 1'b0;
        check("fault_clear_err", 10'(ERR), 10'd0);
        check("fault_restart_rst_oled", 10'(RST_OLED), 10'd0);
`else
        nws = 0;
        for (int c = 0; c < 30; c++) begin
            if (WRITE_START) nws++;
            tick(1);
        end
        check("stall_no_extra_start", 10'(nws), 10'd0);
        check("stall_err_low", 10'(ERR), 10'd0);
`endif
        resp_en = 1'b1;
        RST_N = 1'b0; tick(1); RST_N = 1'b1; tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
